fp_mul_pipe: RTL and testbench

//   Parametrised IEEE-754-style floating-point multiplier, fixed 6-stage pipeline with valid/ready backpressure.

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_mul_pipe_if.sv | 37 +++
 rtl/fp_round_rne.sv | 22 ++
 rtl/fp_mul_pipe.sv | 178 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format sizing, operand classes, canonical NaN, flag bit positions.
package fp_pkg;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    localparam int unsigned FLAGS_W        = 4;
    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Positive quiet NaN: exponent all ones, only the fraction MSB set; callers truncate to W.
    function automatic logic [63:0] fp_canon_nan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe; flags_out exists only with FP_MUL_FLAGS_EN.
interface fp_mul_pipe_if import fp_pkg::*; #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) ();
    localparam int unsigned W = fp_width(EXP_W, MAN_W);

    logic             valid_in;
    logic             ready_out;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic [TAG_W-1:0] tag_in;
    logic             valid_out;
    logic             ready_in;
    logic [W-1:0]     c_out;
    logic [TAG_W-1:0] tag_out;
`ifdef FP_MUL_FLAGS_EN
    logic [FLAGS_W-1:0] flags_out;
`endif

    modport master (
        output valid_in, a_in, b_in, tag_in, ready_in,
        input  ready_out, valid_out, c_out, tag_out
`ifdef FP_MUL_FLAGS_EN
        , input flags_out
`endif
    );

    modport slave (
        input  valid_in, a_in, b_in, tag_in, ready_in,
        output ready_out, valid_out, c_out, tag_out
`ifdef FP_MUL_FLAGS_EN
        , output flags_out
`endif
    );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on an already normalised fraction; a carry out renormalises via exponent +1.
module fp_round_rne #(
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned EXP_XW = 10
) (
    input  logic                     [MAN_W-1:0]  frac,
    input  logic signed              [EXP_XW-1:0] exp,
    input  logic                                  guard,
    input  logic                                  sticky,
    output logic                     [MAN_W-1:0]  frac_rnd,
    output logic signed              [EXP_XW-1:0] exp_rnd
);
    localparam int unsigned SW = MAN_W + 1;

    logic round_up;
    logic carry;

    assign round_up = guard & (sticky | frac[0]);
    // All-ones fraction + 1 wraps to zero, which is exactly the renormalised 1.000 fraction.
    assign {carry, frac_rnd} = SW'(frac) + SW'(round_up);
    assign exp_rnd = exp + EXP_XW'(carry);
endmodule

// File: rtl/fp_mul_pipe.sv
// Six-stage parametrised floating-point multiplier with global-stall backpressure and tag sideband.
// Define FP_MUL_FLAGS_EN to build the {invalid, overflow, underflow, inexact} flag pipeline.
module fp_mul_pipe import fp_pkg::*; #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input logic          clk_in,
    input logic          rst_in,
    fp_mul_pipe_if.slave bus
);
    localparam int unsigned W  = fp_width(EXP_W, MAN_W);
    localparam int unsigned F  = MAN_W + 1;
    localparam int unsigned PW = 2 * F;
    localparam int unsigned XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS     = XW'(fp_bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == EXP_ONES) return (f != '0) ? NAN : INF;
        if (e == '0) return ZERO;
        return NORMAL;
    endfunction

    logic adv;
    logic s1_v, s2_v, s3_v, s4_v, s5_v;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;

    logic                 s1_sign;
    logic [EXP_W-1:0]     s1_ea, s1_eb;
    logic [F-1:0]         s1_ma, s1_mb;
    fp_class_e            s1_ca, s1_cb;
    logic [TAG_W-1:0]     s1_tag, s2_tag, s3_tag, s4_tag, s5_tag;
    logic                 s2_sign, s3_sign, s4_sign, s5_sign;
    logic signed [XW-1:0] s2_exp, s3_exp, s4_exp, s5_exp;
    logic [PW-1:0]        s2_prod, s3_prod;
    logic                 s2_nan, s3_nan, s4_nan, s5_nan;
    logic                 s2_inf, s3_inf, s4_inf, s5_inf;
    logic                 s2_zero, s3_zero, s4_zero, s5_zero;
    logic [MAN_W-1:0]     s4_frac, s5_frac;
    logic                 s4_guard, s4_sticky;
    logic                 hi;
    logic [MAN_W-1:0]     frac_rnd;
    logic signed [XW-1:0] exp_rnd;
    logic                 fin, is_ovf, is_unf;
    logic [W-1:0]         c_nxt;
`ifdef FP_MUL_FLAGS_EN
    logic                 s5_inexact;
    logic [FLAGS_W-1:0]   flags_nxt;
`endif

    // A single enable for every stage: the pipe moves only when the output slot can drain.
    assign adv           = !bus.valid_out || bus.ready_in;
    assign bus.ready_out = adv;

    assign a_exp  = bus.a_in[W-2 -: EXP_W];
    assign b_exp  = bus.b_in[W-2 -: EXP_W];
    assign a_frac = bus.a_in[MAN_W-1:0];
    assign b_frac = bus.b_in[MAN_W-1:0];
    assign hi     = s3_prod[PW-1];

    fp_round_rne #(.MAN_W(MAN_W), .EXP_XW(XW)) u_round (
        .frac     (s4_frac),
        .exp      (s4_exp),
        .guard    (s4_guard),
        .sticky   (s4_sticky),
        .frac_rnd (frac_rnd),
        .exp_rnd  (exp_rnd)
    );

    // Special-case select and pack, in priority order NaN, Inf, zero, overflow, flush-to-zero.
    assign fin    = !(s5_nan || s5_inf || s5_zero);
    assign is_ovf = fin && (s5_exp >= EXP_MAX);
    assign is_unf = fin && !is_ovf && (s5_exp < EXP_ONE);

    always_comb begin
        c_nxt = {s5_sign, s5_exp[EXP_W-1:0], s5_frac};
        if (s5_nan)                 c_nxt = CANON_NAN;
        else if (s5_inf || is_ovf)  c_nxt = {s5_sign, EXP_ONES, {MAN_W{1'b0}}};
        else if (s5_zero || is_unf) c_nxt = {s5_sign, {(W-1){1'b0}}};
    end

`ifdef FP_MUL_FLAGS_EN
    always_comb begin
        flags_nxt                 = '0;
        flags_nxt[FLAG_INVALID]   = s5_nan;
        flags_nxt[FLAG_OVERFLOW]  = is_ovf;
        flags_nxt[FLAG_UNDERFLOW] = is_unf;
        flags_nxt[FLAG_INEXACT]   = fin && (s5_inexact || is_ovf || is_unf);
    end
`endif

    // Valid chain and output register; reset drops everything in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_v          <= 1'b0;
            s2_v          <= 1'b0;
            s3_v          <= 1'b0;
            s4_v          <= 1'b0;
            s5_v          <= 1'b0;
            bus.valid_out <= 1'b0;
            bus.c_out     <= '0;
            bus.tag_out   <= '0;
`ifdef FP_MUL_FLAGS_EN
            bus.flags_out <= '0;
`endif
        end else if (adv) begin
            s1_v          <= bus.valid_in;
            s2_v          <= s1_v;
            s3_v          <= s2_v;
            s4_v          <= s3_v;
            s5_v          <= s4_v;
            bus.valid_out <= s5_v;
            bus.c_out     <= c_nxt;
            bus.tag_out   <= s5_tag;
`ifdef FP_MUL_FLAGS_EN
            bus.flags_out <= flags_nxt;
`endif
        end
    end

    // Datapath stages S1..S5; contents are qualified by the valid chain, so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (adv) begin
            s1_sign   <= bus.a_in[W-1] ^ bus.b_in[W-1];
            s1_ea     <= a_exp;
            s1_eb     <= b_exp;
            s1_ma     <= {a_exp != '0, a_frac};
            s1_mb     <= {b_exp != '0, b_frac};
            s1_ca     <= classify(a_exp, a_frac);
            s1_cb     <= classify(b_exp, b_frac);
            s1_tag    <= bus.tag_in;

            s2_sign   <= s1_sign;
            s2_exp    <= XW'(s1_ea) + XW'(s1_eb) - BIAS;
            s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
            s2_nan    <= (s1_ca == NAN) || (s1_cb == NAN) ||
                         (s1_ca == INF && s1_cb == ZERO) || (s1_ca == ZERO && s1_cb == INF);
            s2_inf    <= (s1_ca == INF) || (s1_cb == INF);
            s2_zero   <= (s1_ca == ZERO) || (s1_cb == ZERO);
            s2_tag    <= s1_tag;

            s3_sign   <= s2_sign;
            s3_exp    <= s2_exp;
            s3_prod   <= s2_prod;
            s3_nan    <= s2_nan;
            s3_inf    <= s2_inf;
            s3_zero   <= s2_zero;
            s3_tag    <= s2_tag;

            s4_sign   <= s3_sign;
            s4_exp    <= s3_exp + XW'(hi);
            s4_frac   <= hi ? s3_prod[PW-2 -: MAN_W] : s3_prod[PW-3 -: MAN_W];
            s4_guard  <= hi ? s3_prod[MAN_W] : s3_prod[MAN_W-1];
            s4_sticky <= hi ? |s3_prod[MAN_W-1:0] : |s3_prod[MAN_W-2:0];
            s4_nan    <= s3_nan;
            s4_inf    <= s3_inf;
            s4_zero   <= s3_zero;
            s4_tag    <= s3_tag;

            s5_sign   <= s4_sign;
            s5_exp    <= exp_rnd;
            s5_frac   <= frac_rnd;
            s5_nan    <= s4_nan;
            s5_inf    <= s4_inf;
            s5_zero   <= s4_zero;
            s5_tag    <= s4_tag;
`ifdef FP_MUL_FLAGS_EN
            s5_inexact <= s4_guard | s4_sticky;
`endif
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (fp32 format); flags are checked when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_pipe;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  tag;
        logic [3:0]  flags;
        int unsigned stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int unsigned adv_cnt = 0;
    logic [3:0]  tag_ctr = 4'd0;
    exp_t        cur;
    exp_t        sb[$];
    logic        held = 1'b0;
    logic [31:0] hold_c;
    logic [3:0]  hold_tag;

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [63:0] to_dbl(input logic [31:0] f);
        logic [10:0] e;
        e = 11'(f[30:23]) + 11'd896;
        return {1'b0, e, f[22:0], 29'd0};
    endfunction

    // Reference: exact product in double precision, then RNE down to 23 fraction bits with flush-to-zero.
    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st, rnd;
        logic [63:0] pb;
        real p;
        int e, fr;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        r.tag = 4'd0; r.stamp = 0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            r.c = 32'h7FC00000; r.flags = 4'b1000;
        end else if (a_inf || b_inf) begin
            r.c = {s, 8'hFF, 23'd0}; r.flags = 4'b0000;
        end else if (a_zero || b_zero) begin
            r.c = {s, 31'd0}; r.flags = 4'b0000;
        end else begin
            p  = $bitstoreal(to_dbl(a)) * $bitstoreal(to_dbl(b));
            pb = $realtobits(p);
            e  = int'(pb[62:52]) - 896;
            fr = int'(pb[51:29]);
            g  = pb[28];
            st = |pb[27:0];
            rnd = g && (st || pb[29]);
            fr = fr + int'(rnd);
            if (fr == 32'h0080_0000) begin
                fr = 0;
                e  = e + 1;
            end
            if (e >= 255) begin
                r.c = {s, 8'hFF, 23'd0}; r.flags = 4'b0101;
            end else if (e < 1) begin
                r.c = {s, 31'd0}; r.flags = 4'b0011;
            end else begin
                r.c = {s, 8'(e), 23'(fr)}; r.flags = {3'b000, g | st};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        if ($urandom_range(1) == 1)
            return {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom)};
        return 32'($urandom);
    endfunction

    // Monitor: pushes on input transfer, pops and compares on output transfer, checks stall/latency rules.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            check_eq("ready_out", 64'(bus.ready_out), 64'(!bus.valid_out || bus.ready_in));
            if (held) begin
                check_eq("stall_valid", 64'(bus.valid_out), 64'd1);
                check_eq("stall_c", 64'(bus.c_out), 64'(hold_c));
                check_eq("stall_tag", 64'(bus.tag_out), 64'(hold_tag));
            end
            if (bus.valid_out && !held) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h expected none at %0t", bus.c_out, $time);
                end else begin
                    check_eq("latency", 64'(adv_cnt - sb[0].stamp), 64'd6);
                end
            end
            if (bus.valid_out && bus.ready_in && sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("c_out", 64'(bus.c_out), 64'(e.c));
                check_eq("tag_out", 64'(bus.tag_out), 64'(e.tag));
`ifdef FP_MUL_FLAGS_EN
                check_eq("flags_out", 64'(bus.flags_out), 64'(e.flags));
`endif
            end
            if (bus.valid_in && bus.ready_out) begin
                e = cur;
                e.stamp = adv_cnt;
                sb.push_back(e);
            end
            held     = bus.valid_out && !bus.ready_in;
            hold_c   = bus.c_out;
            hold_tag = bus.tag_out;
            if (!bus.valid_out || bus.ready_in) adv_cnt++;
        end
    end

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c_exp, input logic [3:0] f_exp);
        int n;
        @(posedge clk); #1;
        bus.valid_in = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.tag_in   = tag_ctr;
        cur.c        = c_exp;
        cur.tag      = tag_ctr;
        cur.flags    = f_exp;
        cur.stamp    = 0;
        tag_ctr      = tag_ctr + 4'd1;
        n = 0;
        @(negedge clk);
        while (!bus.ready_out && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ready_out) begin
            n_checks++; n_fail++;
            $display("FAIL input_timeout: ready_out stuck low at %0t", $time);
        end
    endtask

    task automatic drive_model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        r = ref_mul(a, b);
        drive_op(a, b, r.c, r.flags);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding at %0t", sb.size(), $time);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.tag_in   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check_eq("rst_c_out", 64'(bus.c_out), 64'd0);
        check_eq("rst_tag_out", 64'(bus.tag_out), 64'd0);
`ifdef FP_MUL_FLAGS_EN
        check_eq("rst_flags_out", 64'(bus.flags_out), 64'd0);
`endif

        // Directed vectors with hand-derived results, issued back to back.
        drive_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        drive_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
        drive_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        drive_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        drive_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        drive_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        drive_op(32'h8D800000, 32'h0D800000, 32'h80000000, 4'b0011);
        drive_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
        drive_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        drive_op(32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000);
        drive_op(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        drive_op(32'h3FFFFFFF, 32'h40000000, 32'h407FFFFF, 4'b0000);
        go_idle();
        drain();

        // Random operands with random downstream stalls.
        fork
            begin
                for (int i = 0; i < 40; i++) drive_model(rand_op(), rand_op());
                go_idle();
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk); #1;
                    bus.ready_in = ($urandom_range(3) != 0);
                end
                @(posedge clk); #1;
                bus.ready_in = 1'b1;
            end
        join
        drain();

        // Eight back-to-back ops with a three-cycle downstream stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_model({1'b0, 8'(120 + i), 23'($urandom)}, {1'b1, 8'(130 - i), 23'($urandom)});
                go_idle();
            end
            begin
                repeat (9) @(posedge clk);
                #1 bus.ready_in = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.ready_in = 1'b1;
            end
        join
        drain();

        // Reset with four ops in flight: nothing stale may emerge, the next op completes normally.
        for (int i = 0; i < 4; i++) drive_model(rand_op(), rand_op());
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid_out", 64'(bus.valid_out), 64'd0);
        repeat (12) @(negedge clk);
        drive_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        go_idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
